fifo_buffer: RTL and testbench

//  Synchronous byte FIFO that captures the digest bytes driven onto the shared
//  RAM data bus during the SHA-256 write phase. Bytes are replayed in order

---
 rtl/fifo_buffer_if.sv | 15 +
 rtl/fifo_buffer.sv | 73 +++++++
 tb/tb_fifo_buffer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/fifo_buffer_if.sv
// Handshake and data bundle for the digest-capture byte FIFO.
// The producer/consumer side uses master; the FIFO itself uses slave.
interface fifo_buffer_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  wr;
    logic                  rd;
    logic [DATA_WIDTH-1:0] din;
    logic                  empty;
    logic                  full;
    logic [DATA_WIDTH-1:0] dout;

    modport master (output wr, rd, din, input empty, full, dout);
    modport slave  (input wr, rd, din, output empty, full, dout);
endinterface

// File: rtl/fifo_buffer.sv
// Synchronous byte FIFO that captures SHA-256 digest bytes and replays them in order.
// Occupancy is tracked by a counter, so pointer wrap never decides full/empty.
module fifo_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
) (
    input logic          clock,
    input logic          reset,
    fifo_buffer_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = DEPTH[ADDR_WIDTH:0];

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] rptr;
    logic [ADDR_WIDTH:0]   count;
    logic [ADDR_WIDTH:0]   count_next;
    logic                  empty_q;
    logic                  full_q;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  do_wr;
    logic                  do_rd;

    // A read in the same cycle frees a slot, so a write while full still succeeds.
    assign do_rd = bus.rd & ~empty_q;
    assign do_wr = bus.wr & (~full_q | do_rd);

    always_comb begin
        count_next = count;
        if (do_wr && !do_rd) begin
            count_next = count + 1'b1;
        end else if (do_rd && !do_wr) begin
            count_next = count - 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            dout_q  <= '0;
        end else begin
            if (do_wr) begin
                wptr <= wptr + 1'b1;
            end
            if (do_rd) begin
                rptr   <= rptr + 1'b1;
                dout_q <= mem[rptr];
            end
            count   <= count_next;
            empty_q <= (count_next == '0);
            full_q  <= (count_next == DEPTH_CNT);
        end
    end

    // NOTE: the storage array is deliberately left out of reset; its contents are
    // never observable before being written, and this keeps it mappable to RAM.
    always_ff @(posedge clock) begin
        if (!reset && do_wr) begin
            mem[wptr] <= bus.din;
        end
    end

    assign bus.empty = empty_q;
    assign bus.full  = full_q;
    assign bus.dout  = dout_q;
endmodule

// File: tb/tb_fifo_buffer.sv
// Directed self-checking bench for fifo_buffer: reset, ordering, full/empty
// boundaries, simultaneous read/write, pointer wrap and mid-stream reset.
module tb_fifo_buffer;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    fifo_buffer_if #(.DATA_WIDTH(8)) bus ();

    fifo_buffer #(.DATA_WIDTH(8), .ADDR_WIDTH(5)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        bus.wr  = 1'b1;
        bus.din = d;
        tick();
        bus.wr  = 1'b0;
        bus.din = 'x;
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        bus.rd = 1'b1;
        tick();
        bus.rd = 1'b0;
        check(tag, bus.dout, exp);
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] vec [3];
        vec[0] = 8'hA5;
        vec[1] = 8'h3C;
        vec[2] = 8'hFF;
        bus.wr  = 1'b0;
        bus.rd  = 1'b0;
        bus.din = '0;

        // 1: reset state, then reads on an empty FIFO are ignored
        tick();
        tick();
        check("rst_empty", bus.empty, 1);
        check("rst_full", bus.full, 0);
        check("rst_dout", bus.dout, 8'h00);
        reset  = 1'b0;
        bus.rd = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rd_empty_dout", bus.dout, 8'h00);
            check("rd_empty_flag", bus.empty, 1);
        end
        bus.rd = 1'b0;

        // 2: three bytes in order
        for (int i = 0; i < 3; i++) push(vec[i]);
        check("t2_not_empty", bus.empty, 0);
        for (int i = 0; i < 3; i++) pop_check("t2_dout", vec[i]);
        check("t2_empty", bus.empty, 1);

        // 3: fill to 32, drop 33rd write, drain
        for (int i = 0; i < 32; i++) begin
            push(8'(i));
            if (i == 30) check("t3_not_full_31", bus.full, 0);
        end
        check("t3_full", bus.full, 1);
        push(8'hEE);
        check("t3_full_after_drop", bus.full, 1);
        for (int i = 0; i < 32; i++) pop_check("t3_dout", 8'(i));
        check("t3_empty", bus.empty, 1);
        tick();
        check("t3_dout_hold", bus.dout, 8'h1F);

        // 4: simultaneous read/write while full
        for (int i = 0; i < 32; i++) push(8'(i));
        bus.wr  = 1'b1;
        bus.rd  = 1'b1;
        bus.din = 8'h77;
        tick();
        bus.wr  = 1'b0;
        bus.rd  = 1'b0;
        check("t4_dout", bus.dout, 8'h00);
        check("t4_full", bus.full, 1);
        for (int i = 1; i < 32; i++) pop_check("t4_drain", 8'(i));
        pop_check("t4_last", 8'h77);
        check("t4_empty", bus.empty, 1);

        // 5: pointer wrap-around
        d = 8'h80;
        for (int loop = 0; loop < 3; loop++) begin
            for (int i = 0; i < 20; i++) push(d + 8'(i));
            for (int i = 0; i < 20; i++) pop_check("t5_wrap", d + 8'(i));
            d = d + 8'd20;
        end
        check("t5_empty", bus.empty, 1);

        // mid-occupancy simultaneous read/write keeps count and flags
        push(8'h11);
        push(8'h22);
        bus.wr  = 1'b1;
        bus.rd  = 1'b1;
        bus.din = 8'h33;
        tick();
        bus.wr  = 1'b0;
        bus.rd  = 1'b0;
        check("mid_rw_dout", bus.dout, 8'h11);
        check("mid_rw_empty", bus.empty, 0);
        check("mid_rw_full", bus.full, 0);
        pop_check("mid_rw_pop1", 8'h22);
        pop_check("mid_rw_pop2", 8'h33);
        check("mid_rw_drained", bus.empty, 1);

        // 6: reset with 10 entries stored
        for (int i = 0; i < 10; i++) push(8'h40 + 8'(i));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_empty", bus.empty, 1);
        check("t6_full", bus.full, 0);
        check("t6_dout", bus.dout, 8'h00);
        push(8'h5A);
        pop_check("t6_dout_5a", 8'h5A);
        check("t6_empty_end", bus.empty, 1);

        // rd & wr while empty: write succeeds, read ignored
        bus.wr  = 1'b1;
        bus.rd  = 1'b1;
        bus.din = 8'hC3;
        tick();
        bus.wr  = 1'b0;
        bus.rd  = 1'b0;
        check("rw_empty_hold", bus.dout, 8'h5A);
        check("rw_empty_stored", bus.empty, 0);
        pop_check("rw_empty_pop", 8'hC3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
